// File: rtl/predictor_stat_tracker_pkg.sv
// predictor_stat_tracker_pkg
// Shared definitions for the predictor statistics tracker:
//   - trend state codes (STRONG_BAD .. STRONG_GOOD) and their one-hot decodes
//   - the default accuracy counter width (must match the downstream arbiter)
//   - the in-flight queue entry layout {SP, LHP, GHP}
//   - decode_trend(): trend state -> one-hot decode
package predictor_stat_tracker_pkg;

  localparam int DEFAULT_STAT_COUNTER_WIDTH = 5;

  typedef enum logic [1:0] {
    STRONG_BAD  = 2'd0,
    WEAK_BAD    = 2'd1,
    WEAK_GOOD   = 2'd2,
    STRONG_GOOD = 2'd3
  } trend_t;

  localparam logic [3:0] TREND_DEC_STRONG_BAD  = 4'b0001;
  localparam logic [3:0] TREND_DEC_WEAK_BAD    = 4'b0010;
  localparam logic [3:0] TREND_DEC_WEAK_GOOD   = 4'b0100;
  localparam logic [3:0] TREND_DEC_STRONG_GOOD = 4'b1000;

  // One captured prediction: the three predictors' taken/not-taken guesses.
  typedef struct packed {
    logic sp;
    logic lhp;
    logic ghp;
  } pred_entry_t;

  function automatic logic [3:0] decode_trend(input trend_t t);
    logic [3:0] dec;
    case (t)
      STRONG_BAD:  dec = TREND_DEC_STRONG_BAD;
      WEAK_BAD:    dec = TREND_DEC_WEAK_BAD;
      WEAK_GOOD:   dec = TREND_DEC_WEAK_GOOD;
      STRONG_GOOD: dec = TREND_DEC_STRONG_GOOD;
      default:     dec = TREND_DEC_WEAK_GOOD;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/predictor_stat_tracker_if.sv
// predictor_stat_tracker_if
// Fetch/execute side handshake into the statistics tracker.
//   pred_valid / pred_ready        : capture of one prediction triple at fetch
//   SP/LHP/GHP_pred_in             : the three predictors' taken/not-taken guesses
//   resolve_valid / resolve_taken  : oldest in-flight branch resolved, actual outcome
//   flush                          : discard all wrong-path in-flight entries
// master = pipeline driving the tracker, slave = the tracker itself.
interface predictor_stat_tracker_if;

  logic pred_valid;
  logic pred_ready;
  logic SP_pred_in;
  logic LHP_pred_in;
  logic GHP_pred_in;
  logic resolve_valid;
  logic resolve_taken;
  logic flush;

  modport master (
    output pred_valid,
    output SP_pred_in,
    output LHP_pred_in,
    output GHP_pred_in,
    output resolve_valid,
    output resolve_taken,
    output flush,
    input  pred_ready
  );

  modport slave (
    input  pred_valid,
    input  SP_pred_in,
    input  LHP_pred_in,
    input  GHP_pred_in,
    input  resolve_valid,
    input  resolve_taken,
    input  flush,
    output pred_ready
  );

endinterface

// File: rtl/predictor_stat_tracker_stat_trend_counter.sv
// stat_trend_counter
// One predictor's accuracy bookkeeping: a saturating accuracy counter plus a
// 2-bit trend state machine. On update, a correct prediction adds 1 (saturating
// at 2^W-1) and moves the trend up; a wrong one subtracts WRONG_PENALTY
// (clamped at 0) and moves the trend down.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   update        : score one resolved prediction this cycle
//   correct       : that prediction matched the actual outcome
//   stat_count    : registered accuracy count
//   trend_decode  : registered one-hot trend
module stat_trend_counter
  import predictor_stat_tracker_pkg::*;
#(
  parameter int STAT_COUNTER_WIDTH = DEFAULT_STAT_COUNTER_WIDTH,
  parameter int WRONG_PENALTY      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          update,
  input  logic                          correct,
  output logic [STAT_COUNTER_WIDTH-1:0] stat_count,
  output logic [3:0]                    trend_decode
);

  localparam int W = STAT_COUNTER_WIDTH;

  typedef logic [W:0] wide_t;

  localparam wide_t CNT_MAX = {1'b0, {W{1'b1}}};
  localparam wide_t PENALTY = wide_t'(WRONG_PENALTY);
  localparam wide_t ONE     = wide_t'(1);

  logic [W-1:0] count_r;
  logic [W-1:0] count_next_s;
  wide_t        sum_s;
  wide_t        diff_s;
  trend_t       trend_r;
  trend_t       trend_next_s;
  logic [3:0]   decode_r;

  // Counter next value; arithmetic one bit wider so overflow/underflow is visible.
  always_comb begin
    sum_s        = {1'b0, count_r} + ONE;
    diff_s       = {1'b0, count_r} - PENALTY;
    count_next_s = count_r;
    if (update) begin
      if (correct) begin
        if (sum_s > CNT_MAX) begin
          count_next_s = CNT_MAX[W-1:0];
        end else begin
          count_next_s = sum_s[W-1:0];
        end
      end else begin
        // Top bit set means the subtraction went below zero.
        if (diff_s[W]) begin
          count_next_s = {W{1'b0}};
        end else begin
          count_next_s = diff_s[W-1:0];
        end
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Trend next state: step toward STRONG_GOOD on correct, STRONG_BAD on wrong.
  always_comb begin
    trend_next_s = trend_r;
    if (update) begin
      case (trend_r)
        STRONG_BAD:  trend_next_s = correct ? WEAK_BAD    : STRONG_BAD;
        WEAK_BAD:    trend_next_s = correct ? WEAK_GOOD   : STRONG_BAD;
        WEAK_GOOD:   trend_next_s = correct ? STRONG_GOOD : WEAK_BAD;
        STRONG_GOOD: trend_next_s = correct ? STRONG_GOOD : WEAK_GOOD;
        default:     trend_next_s = WEAK_GOOD;
      endcase
    end else begin
      trend_next_s = trend_r;
    end
  end

  // Trend state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trend_r <= WEAK_GOOD;
    end else begin
      trend_r <= trend_next_s;
    end
  end

  // Count and decoded trend registers; decode is registered from the next state
  // so trend_decode changes in the same cycle as trend_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= {W{1'b0}};
      decode_r <= TREND_DEC_WEAK_GOOD;
    end else begin
      count_r  <= count_next_s;
      decode_r <= decode_trend(trend_next_s);
    end
  end

  assign stat_count   = count_r;
  assign trend_decode = decode_r;

endmodule

// File: rtl/predictor_stat_tracker.sv
// predictor_stat_tracker
// Produces per-predictor confidence inputs for the three-way branch prediction
// arbiter. Predictions {SP, LHP, GHP} are captured at fetch into an in-order
// in-flight queue; when the oldest branch resolves, its entry is popped and each
// predictor is scored by its own stat_trend_counter. A flush discards all
// in-flight entries but never touches the accumulated statistics.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   bus (slave)              : prediction capture / resolve / flush handshake
//   SP/LHP/GHP_stat_count    : registered accuracy counts
//   SP/LHP/GHP_trend_decode  : registered one-hot trends
//   inflight_count           : registered queue occupancy
//   resolve_underflow        : registered one-cycle pulse, resolve on empty queue
module predictor_stat_tracker
  import predictor_stat_tracker_pkg::*;
#(
  parameter int STAT_COUNTER_WIDTH = DEFAULT_STAT_COUNTER_WIDTH,
  parameter int QUEUE_DEPTH        = 4,
  parameter int WRONG_PENALTY      = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  predictor_stat_tracker_if.slave         bus,
  output logic [STAT_COUNTER_WIDTH-1:0]   SP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0]   LHP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0]   GHP_stat_count,
  output logic [3:0]                      SP_trend_decode,
  output logic [3:0]                      LHP_trend_decode,
  output logic [3:0]                      GHP_trend_decode,
  output logic [$clog2(QUEUE_DEPTH):0]    inflight_count,
  output logic                            resolve_underflow
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [OCC_W-1:0] occ_t;

  localparam occ_t OCC_FULL = occ_t'(QUEUE_DEPTH);
  localparam occ_t OCC_ONE  = occ_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  pred_entry_t queue_r [QUEUE_DEPTH];
  ptr_t        head_r;
  ptr_t        tail_r;
  occ_t        occ_r;
  ptr_t        head_next_s;
  ptr_t        tail_next_s;
  occ_t        occ_next_s;

  logic        empty_s;
  logic        full_s;
  logic        pop_s;
  logic        push_s;
  logic        ready_s;
  logic        underflow_r;
  pred_entry_t head_entry_s;
  pred_entry_t push_entry_s;

  assign empty_s = (occ_r == {OCC_W{1'b0}});
  assign full_s  = (occ_r == OCC_FULL);
  assign pop_s   = bus.resolve_valid & ~empty_s;
  // A pop in the same cycle frees the head slot, so a full queue can still
  // take a new entry while the oldest branch resolves.
  assign ready_s = ~full_s | pop_s;
  assign push_s  = bus.pred_valid & ready_s & ~bus.flush;

  assign bus.pred_ready = ready_s;

  assign head_entry_s = queue_r[head_r];
  assign push_entry_s = '{sp: bus.SP_pred_in, lhp: bus.LHP_pred_in, ghp: bus.GHP_pred_in};

  // Queue pointer/occupancy next state; flush wins after the head was scored.
  always_comb begin
    head_next_s = head_r;
    tail_next_s = tail_r;
    occ_next_s  = occ_r;
    if (bus.flush) begin
      head_next_s = {PTR_W{1'b0}};
      tail_next_s = {PTR_W{1'b0}};
      occ_next_s  = {OCC_W{1'b0}};
    end else begin
      if (pop_s) begin
        head_next_s = head_r + PTR_ONE;
      end else begin
        head_next_s = head_r;
      end
      if (push_s) begin
        tail_next_s = tail_r + PTR_ONE;
      end else begin
        tail_next_s = tail_r;
      end
      if (push_s && !pop_s) begin
        occ_next_s = occ_r + OCC_ONE;
      end else if (pop_s && !push_s) begin
        occ_next_s = occ_r - OCC_ONE;
      end else begin
        occ_next_s = occ_r;
      end
    end
  end

  // Queue pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      occ_r  <= {OCC_W{1'b0}};
    end else begin
      head_r <= head_next_s;
      tail_r <= tail_next_s;
      occ_r  <= occ_next_s;
    end
  end

  // Queue storage; a slot is written only on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        queue_r[i] <= '{sp: 1'b0, lhp: 1'b0, ghp: 1'b0};
      end
    end else if (push_s) begin
      queue_r[tail_r] <= push_entry_s;
    end else begin
      queue_r[tail_r] <= queue_r[tail_r];
    end
  end

  // Underflow pulse register: resolve seen with nothing in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_r <= 1'b0;
    end else begin
      underflow_r <= bus.resolve_valid & empty_s;
    end
  end

  assign inflight_count    = occ_r;
  assign resolve_underflow = underflow_r;

  stat_trend_counter #(
    .STAT_COUNTER_WIDTH (STAT_COUNTER_WIDTH),
    .WRONG_PENALTY      (WRONG_PENALTY)
  ) u_sp (
    .clk          (clk),
    .rst          (rst),
    .update       (pop_s),
    .correct      (~(head_entry_s.sp ^ bus.resolve_taken)),
    .stat_count   (SP_stat_count),
    .trend_decode (SP_trend_decode)
  );

  stat_trend_counter #(
    .STAT_COUNTER_WIDTH (STAT_COUNTER_WIDTH),
    .WRONG_PENALTY      (WRONG_PENALTY)
  ) u_lhp (
    .clk          (clk),
    .rst          (rst),
    .update       (pop_s),
    .correct      (~(head_entry_s.lhp ^ bus.resolve_taken)),
    .stat_count   (LHP_stat_count),
    .trend_decode (LHP_trend_decode)
  );

  stat_trend_counter #(
    .STAT_COUNTER_WIDTH (STAT_COUNTER_WIDTH),
    .WRONG_PENALTY      (WRONG_PENALTY)
  ) u_ghp (
    .clk          (clk),
    .rst          (rst),
    .update       (pop_s),
    .correct      (~(head_entry_s.ghp ^ bus.resolve_taken)),
    .stat_count   (GHP_stat_count),
    .trend_decode (GHP_trend_decode)
  );

endmodule

// File: tb/tb_predictor_stat_tracker.sv
// tb_predictor_stat_tracker
// Randomized and directed stimulus against a queue-based behavioural model of
// the tracker; one compare process checks every output each cycle on the
// falling edge, and directed sections pin the model with literal values.
module tb_predictor_stat_tracker;

  localparam int W    = 5;
  localparam int D    = 4;
  localparam int PEN  = 2;
  localparam int MAXC = 31;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  predictor_stat_tracker_if bus();

  logic [W-1:0] sp_cnt, lhp_cnt, ghp_cnt;
  logic [3:0]   sp_dec, lhp_dec, ghp_dec;
  logic [2:0]   inflight;
  logic         underflow;

  predictor_stat_tracker #(
    .STAT_COUNTER_WIDTH (W),
    .QUEUE_DEPTH        (D),
    .WRONG_PENALTY      (PEN)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .SP_stat_count     (sp_cnt),
    .LHP_stat_count    (lhp_cnt),
    .GHP_stat_count    (ghp_cnt),
    .SP_trend_decode   (sp_dec),
    .LHP_trend_decode  (lhp_dec),
    .GHP_trend_decode  (ghp_dec),
    .inflight_count    (inflight),
    .resolve_underflow (underflow)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model: index 0 = SP, 1 = LHP, 2 = GHP.
  int m_cnt [3];
  int m_trend [3];   // 0 = strong bad .. 3 = strong good
  int m_q [$];       // entries {SP,LHP,GHP} as 3-bit integers, oldest first
  bit m_uf;
  int m_sz;
  bit m_rdy;
  int m_e;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]   = 0;
      m_trend[i] = 2;
    end
    m_q.delete();
    m_uf = 1'b0;
  endfunction

  function automatic void model_score(input int e, input bit taken);
    for (int i = 0; i < 3; i++) begin
      bit guess;
      guess = e[2-i];
      if (guess == taken) begin
        m_cnt[i]   = (m_cnt[i] + 1 > MAXC) ? MAXC : m_cnt[i] + 1;
        m_trend[i] = (m_trend[i] == 3) ? 3 : m_trend[i] + 1;
      end else begin
        m_cnt[i]   = (m_cnt[i] - PEN < 0) ? 0 : m_cnt[i] - PEN;
        m_trend[i] = (m_trend[i] == 0) ? 0 : m_trend[i] - 1;
      end
    end
  endfunction

  function automatic int onehot(input int t);
    return 1 << t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each rising edge using the inputs presented that cycle.
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      m_sz  = m_q.size();
      m_uf  = bus.resolve_valid && (m_sz == 0);
      m_rdy = (m_sz < D) || (bus.resolve_valid && m_sz > 0);
      if (bus.resolve_valid && m_sz > 0) begin
        m_e = m_q.pop_front();
        model_score(m_e, bus.resolve_taken);
      end
      if (bus.flush) begin
        m_q.delete();
      end else if (bus.pred_valid && m_rdy) begin
        m_q.push_back({29'd0, bus.SP_pred_in, bus.LHP_pred_in, bus.GHP_pred_in});
      end
    end
  end

  // Compare process: every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("sp_count",  sp_cnt,  m_cnt[0]);
      check("lhp_count", lhp_cnt, m_cnt[1]);
      check("ghp_count", ghp_cnt, m_cnt[2]);
      check("sp_trend",  sp_dec,  onehot(m_trend[0]));
      check("lhp_trend", lhp_dec, onehot(m_trend[1]));
      check("ghp_trend", ghp_dec, onehot(m_trend[2]));
      check("inflight",  inflight, m_q.size());
      check("underflow", underflow, m_uf);
      check("pred_ready", bus.pred_ready,
            (m_q.size() < D) || (bus.resolve_valid && m_q.size() > 0));
    end
  end

  task automatic step(input logic pv, input logic [2:0] p, input logic rv,
                      input logic rt, input logic fl);
    @(posedge clk);
    #2;
    bus.pred_valid    = pv;
    bus.SP_pred_in    = p[2];
    bus.LHP_pred_in   = p[1];
    bus.GHP_pred_in   = p[0];
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    bus.flush         = fl;
  endtask

  task automatic idle();
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sp_count"},  sp_cnt,  0);
    check({tag, "_lhp_count"}, lhp_cnt, 0);
    check({tag, "_ghp_count"}, ghp_cnt, 0);
    check({tag, "_sp_trend"},  sp_dec,  32'b0100);
    check({tag, "_lhp_trend"}, lhp_dec, 32'b0100);
    check({tag, "_ghp_trend"}, ghp_dec, 32'b0100);
    check({tag, "_ready"},     bus.pred_ready, 1);
    check({tag, "_inflight"},  inflight, 0);
    check({tag, "_underflow"}, underflow, 0);
  endtask

  initial begin
    bus.pred_valid    = 1'b0;
    bus.SP_pred_in    = 1'b0;
    bus.LHP_pred_in   = 1'b0;
    bus.GHP_pred_in   = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.flush         = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state after idle.
    @(negedge clk);
    check_reset_values("reset");

    // One branch {1,0,1}, resolved taken.
    step(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("first_sp_count",  sp_cnt,  1);
    check("first_sp_trend",  sp_dec,  32'b1000);
    check("first_lhp_count", lhp_cnt, 0);
    check("first_lhp_trend", lhp_dec, 32'b0010);
    check("first_ghp_count", ghp_cnt, 1);
    check("first_model_sp",  m_cnt[0], 1);

    // SP saturation upward, then 16 misses down to zero.
    repeat (40) begin
      step(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    end
    idle();
    @(negedge clk);
    check("sat_sp_count", sp_cnt, MAXC);
    check("sat_sp_trend", sp_dec, 32'b1000);
    repeat (16) begin
      step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    end
    idle();
    @(negedge clk);
    check("floor_sp_count", sp_cnt, 0);
    check("floor_sp_trend", sp_dec, 32'b0001);

    // Fill the queue, push+pop while full, then a dropped push.
    repeat (4) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("full_ready", bus.pred_ready, 0);
    check("full_inflight", inflight, 4);
    step(1'b1, 3'b111, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("full_pushpop_ready", bus.pred_ready, 1);
    idle();
    @(negedge clk);
    check("full_pushpop_inflight", inflight, 4);
    step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("full_drop_ready", bus.pred_ready, 0);
    idle();
    @(negedge clk);
    check("full_drop_inflight", inflight, 4);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    idle();

    // Three in flight, flush together with resolve and push.
    repeat (3) step(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'b111, 1'b1, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("flush_inflight", inflight, 0);
    check("flush_model_empty", m_q.size(), 0);

    // Resolve on an empty queue.
    step(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("underflow_pulse", underflow, 1);
    idle();
    @(negedge clk);
    check("underflow_gone", underflow, 0);

    // Push+pop on empty: underflow and the push is kept.
    step(1'b1, 3'b110, 1'b1, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("empty_pushpop_underflow", underflow, 1);
    check("empty_pushpop_inflight", inflight, 1);

    // Reset asserted right after an update edge.
    step(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    bus.resolve_valid = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Randomized traffic.
    repeat (3000) begin
      step(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) == 0));
    end
    idle();
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
